digit_serial_alu: RTL and testbench
===================================

# digit_serial_alu

Parametrised digit-serial ALU engine and the successor to the fixed 8×4-bit nibble loop. It captures two operands and iterates a combinational digit slice over a programmable number of digits, one digit per clock. Propagation runs LSB→MSB or MSB→LSB depending on the command. It exposes a start/busy/done handshake and a final carry, and sits between the instruction decoder and the register file in the small-core datapath.

## Interface
- DIGIT_W, 4: bits per digit.
- DIGITS, 8: digits per word; word width W = DIGIT_W*DIGITS. Must be a power of two, ≥2.
- LEN_W, $clog2(DIGITS): width of `len`.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request; sampled only in IDLE or DONE.
- cmd  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 RSHFT, 6 LSHFT, 7 PASS.
- len  in  LEN_W  active digits minus 1 (0 → one digit).
- cin  in  1  carry-in for ADD; ignored otherwise.
- a  in  W  operand A.
- b  in  W  operand B; this is the shift source for RSHFT/LSHFT.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE; result/carry_out valid.
- result  out  W  registered result.
- carry_out  out  1  final carry / shifted-out bit.

## Operation
- FSM states are IDLE, RUN and DONE.
  - IDLE→RUN on start.
  - RUN→DONE after the last active digit is processed.
  - DONE→RUN on start (back-to-back); otherwise DONE→IDLE.
- On accepting start:
  - Register cmd, len, cin, a, b.
  - Clear result to 0.
  - Load the carry register:
    - ADD: cin.
    - SUB: 1.
    - RSHFT/LSHFT: 0.
    - Others: 0.
  - Load the digit index: `len` for RSHFT, 0 otherwise.
- Each RUN cycle processes digit i and writes result digit i.
- ADD:
  - Digit sum = a_i + b_i + c.
  - Low DIGIT_W bits go to result; the carry register takes the bit above them.
- SUB:
  - Computed as a_i + ~b_i + c.
  - carry_out = 1 means no borrow.
- AND/OR/XOR: bitwise per digit; carry register stays 0.
- PASS: result digit = a_i; carry register stays 0.
- RSHFT:
  - Processes MSB→LSB.
  - Digit result = {c, b_i[DIGIT_W-1:1]}; then c ← b_i[0].
  - Zero is shifted into bit (len+1)*DIGIT_W-1.
- LSHFT:
  - Processes LSB→MSB.
  - Digit result = {b_i[DIGIT_W-2:0], c}; then c ← b_i[DIGIT_W-1].
- carry_out is the carry register after the last digit. It holds until the next accepted start.
- Result digits with index > len remain 0.
- Operand inputs may change freely after start is accepted.
- start while busy=1 is ignored (no queuing).

## Timing
- Start sampled high at edge T0 → RUN from T0. Digits are processed at edges T1…T(len+1).
- DONE occupies the cycle after T(len+1): done=1, busy=0.
- Latency from the start edge to the done cycle is len+2 cycles. Maximum throughput is one operation per len+2 cycles with back-to-back start in DONE.
- result and carry_out change only on an accepted start (cleared/loaded) and during RUN. They are stable from DONE until the next accepted start.
- Reset values: state IDLE, busy 0, done 0, result 0, carry_out 0, index 0; ZERO_OVF flags 0.
- rst has priority over start. Reset mid-RUN aborts with no done pulse; result and carry_out return to 0 on the reset edge.
- len=0: a single RUN cycle, and done one cycle later.
- Digit index never wraps:
  - RSHFT terminates at index 0.
  - Other commands terminate at index len.

## Configuration
- DIGIT_SERIAL_ALU_FLAGS_EN defined: adds output ports `zero` (1) and `ovf` (1), both registered and valid with done.
  - zero = active-width result all zeros.
  - ovf = signed overflow of ADD/SUB on the active width. It is computed as the carry into bit (len+1)*DIGIT_W-1 XOR the carry out of it, and is 0 for other commands.
  - Both clear on accepted start and reset.
- Undefined: the `zero`/`ovf` ports and their logic are absent; all other behaviour is identical.

## Test plan
- ADD, len=7, a=0x0EFFFFFF, b=1, cin=0 → result 0x0F000000, carry_out 0. done exactly 9 cycles after the start edge; busy high 8 cycles.
- SUB, len=7, a=2, b=3 → result 0xFFFFFFFF, carry_out 0; with FLAGS_EN: zero 0, ovf 0.
- ADD, len=2, a=0x00000001, b=0x00000FFE → result 0x00000FFF with digits 3..7 zero, carry_out 0. done 4 cycles after start.
- RSHFT, len=7, b=0x06000001 → result 0x03000000, carry_out 1. LSHFT, len=7, b=0x80000001 → result 0x00000002, carry_out 1.
- Back-to-back: start held high through DONE.
  - First op ADD 0xFFFFFFFF+1 → result 0, carry_out 1, zero 1 (FLAGS_EN).
  - Second op XOR 0xF0F0F0F0^0xFFFF0000 starts in the DONE cycle → 0x0F0FF0F0 nine cycles later.
  - start asserted during RUN is ignored.
- Reset: rst at the 3rd RUN cycle of ADD len=7 → next cycle IDLE, busy 0, result 0, carry_out 0, no done pulse. A subsequent start operates normally.

Source files
------------

// File: rtl/digit_serial_alu.sv
// rtl/digit_serial_alu.sv - digit-serial ALU engine with start/busy/done handshake
//
// Captures two W-bit operands on an accepted start and processes one DIGIT_W-bit
// digit per clock through a combinational slice. SUB, ADD, logic ops, PASS and
// LSHFT walk digits LSB->MSB; RSHFT walks MSB->LSB. Digits above len stay zero.
//
// Optional feature macro: DIGIT_SERIAL_ALU_FLAGS_EN (adds zero/ovf outputs).
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   rst        in   synchronous active-high reset, priority over start
//   start      in   operation request, accepted only in IDLE or DONE
//   cmd[2:0]   in   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 RSHFT, 6 LSHFT, 7 PASS
//   len        in   number of active digits minus one
//   cin        in   carry-in for ADD
//   a, b       in   operands; b is the shift source
//   busy       out  high while digits are being processed
//   done       out  one-cycle pulse, result/carry_out valid
//   result     out  registered result word
//   carry_out  out  final carry, or bit shifted out
//   zero, ovf  out  (FLAGS_EN only) active-width zero and signed overflow

module digit_serial_alu #(
   parameter int DIGIT_W = 4,
   parameter int DIGITS  = 8,
   parameter int LEN_W   = $clog2(DIGITS)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [2:0]                  cmd,
   input  logic [LEN_W-1:0]            len,
   input  logic                        cin,
   input  logic [DIGIT_W*DIGITS-1:0]   a,
   input  logic [DIGIT_W*DIGITS-1:0]   b,
   output logic                        busy,
   output logic                        done,
   output logic [DIGIT_W*DIGITS-1:0]   result,
   output logic                        carry_out
`ifdef DIGIT_SERIAL_ALU_FLAGS_EN
   ,
   output logic                        zero,
   output logic                        ovf
`endif
);

   localparam int W = DIGIT_W * DIGITS;

   localparam logic [2:0] CMD_ADD   = 3'd0;
   localparam logic [2:0] CMD_SUB   = 3'd1;
   localparam logic [2:0] CMD_AND   = 3'd2;
   localparam logic [2:0] CMD_OR    = 3'd3;
   localparam logic [2:0] CMD_XOR   = 3'd4;
   localparam logic [2:0] CMD_RSHFT = 3'd5;
   localparam logic [2:0] CMD_LSHFT = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t              state_q;
   logic                busy_q;
   logic                done_q;
   logic [2:0]          cmd_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    idx_q;
   logic [LEN_W-1:0]    idx_d;
   logic [W-1:0]        a_q;
   logic [W-1:0]        b_q;
   logic [W-1:0]        result_q;
   logic [W-1:0]        result_d;
   logic                c_q;
   logic                c_d;
   logic                last;

   logic [DIGIT_W-1:0]  a_dig;
   logic [DIGIT_W-1:0]  b_dig;
   logic [DIGIT_W-1:0]  b_op;
   logic [DIGIT_W-1:0]  dig_res;
   logic [DIGIT_W:0]    sum;

`ifdef DIGIT_SERIAL_ALU_FLAGS_EN
   logic                zero_q;
   logic                ovf_q;
   logic                ovf_d;
`endif

   assign a_dig = a_q[idx_q*DIGIT_W +: DIGIT_W];
   assign b_dig = b_q[idx_q*DIGIT_W +: DIGIT_W];

   // Digit slice: SUB reuses the adder with inverted b; its carry register was
   // preloaded with 1 to complete the two's complement.
   always_comb begin
      b_op    = (cmd_q == CMD_SUB) ? ~b_dig : b_dig;
      sum     = {1'b0, a_dig} + {1'b0, b_op} + {{DIGIT_W{1'b0}}, c_q};
      dig_res = a_dig;
      c_d     = 1'b0;
      case (cmd_q)
         CMD_ADD, CMD_SUB: begin
            dig_res = sum[DIGIT_W-1:0];
            c_d     = sum[DIGIT_W];
         end
         CMD_AND:   dig_res = a_dig & b_dig;
         CMD_OR:    dig_res = a_dig | b_dig;
         CMD_XOR:   dig_res = a_dig ^ b_dig;
         CMD_RSHFT: begin
            dig_res = {c_q, b_dig[DIGIT_W-1:1]};
            c_d     = b_dig[0];
         end
         CMD_LSHFT: begin
            dig_res = {b_dig[DIGIT_W-2:0], c_q};
            c_d     = b_dig[DIGIT_W-1];
         end
         default:   dig_res = a_dig;
      endcase

      result_d = result_q;
      result_d[idx_q*DIGIT_W +: DIGIT_W] = dig_res;

      // RSHFT counts down to digit 0, everything else counts up to len, so
      // the index never wraps.
      if (cmd_q == CMD_RSHFT) begin
         last  = (idx_q == '0);
         idx_d = idx_q - 1'b1;
      end else begin
         last  = (idx_q == len_q);
         idx_d = idx_q + 1'b1;
      end
   end

`ifdef DIGIT_SERIAL_ALU_FLAGS_EN
   // Carry into the digit MSB is recovered from the sum bit: s ^ a ^ b.
   always_comb begin
      ovf_d = 1'b0;
      if (cmd_q == CMD_ADD || cmd_q == CMD_SUB) begin
         ovf_d = sum[DIGIT_W] ^ (sum[DIGIT_W-1] ^ a_dig[DIGIT_W-1] ^ b_op[DIGIT_W-1]);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cmd_q    <= CMD_ADD;
         len_q    <= '0;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         c_q      <= 1'b0;
`ifdef DIGIT_SERIAL_ALU_FLAGS_EN
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q  <= S_RUN;
                  busy_q   <= 1'b1;
                  cmd_q    <= cmd;
                  len_q    <= len;
                  a_q      <= a;
                  b_q      <= b;
                  result_q <= '0;
                  c_q      <= (cmd == CMD_ADD) ? cin : (cmd == CMD_SUB);
                  idx_q    <= (cmd == CMD_RSHFT) ? len : '0;
`ifdef DIGIT_SERIAL_ALU_FLAGS_EN
                  zero_q   <= 1'b0;
                  ovf_q    <= 1'b0;
`endif
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            S_RUN: begin
               result_q <= result_d;
               c_q      <= c_d;
               if (last) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
`ifdef DIGIT_SERIAL_ALU_FLAGS_EN
                  zero_q  <= (result_d == '0);
                  ovf_q   <= ovf_d;
`endif
               end else begin
                  idx_q <= idx_d;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign result    = result_q;
   assign carry_out = c_q;
`ifdef DIGIT_SERIAL_ALU_FLAGS_EN
   assign zero      = zero_q;
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_alu.sv
// tb/tb_digit_serial_alu.sv - directed self-checking bench for digit_serial_alu

module tb_digit_serial_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  cmd;
   logic [2:0]  len;
   logic        cin;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        carry_out;
`ifdef DIGIT_SERIAL_ALU_FLAGS_EN
   logic        zero;
   logic        ovf;
`endif

   int errors = 0;
   int checks = 0;

   digit_serial_alu #(.DIGIT_W(4), .DIGITS(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .cmd       (cmd),
      .len       (len),
      .cin       (cin),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .carry_out (carry_out)
`ifdef DIGIT_SERIAL_ALU_FLAGS_EN
      ,
      .zero      (zero),
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   // Starts one operation, scrambles the inputs after acceptance, and waits for
   // done. n counts clock edges from the start edge (inclusive) to the edge that
   // raises done; bcnt counts cycles with busy high. n reaches 40 on timeout.
   task automatic run_op(input logic [2:0] c, input logic [2:0] l, input logic ci,
                         input logic [31:0] aa, input logic [31:0] bb,
                         output int n, output int bcnt);
      @(negedge clk);
      cmd = c; len = l; cin = ci; a = aa; b = bb; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
      cmd = 3'($urandom_range(0, 7)); len = 3'($urandom_range(0, 7));
      n = 1; bcnt = 0;
      while (!done && n < 40) begin
         if (busy) bcnt++;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b1; cmd = 3'd0; len = 3'd7; cin = 1'b1;
      a = 32'h1234_5678; b = 32'h1111_1111;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl: busy=%b done=%b, expected 0 0", busy, done);
      end
      checks++;
      if (result !== 32'h0 || carry_out !== 1'b0) begin
         errors++; $display("FAIL reset_data: result=%h carry=%b, expected 0 0", result, carry_out);
      end
`ifdef DIGIT_SERIAL_ALU_FLAGS_EN
      checks++;
      if (zero !== 1'b0 || ovf !== 1'b0) begin
         errors++; $display("FAIL reset_flags: zero=%b ovf=%b, expected 0 0", zero, ovf);
      end
`endif
      start = 1'b0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_add;
      int n, bc;
      run_op(3'd0, 3'd7, 1'b0, 32'h0EFF_FFFF, 32'h0000_0001, n, bc);
      checks++;
      if (n !== 9) begin errors++; $display("FAIL add_latency: got %0d, expected 9", n); end
      checks++;
      if (bc !== 8) begin errors++; $display("FAIL add_busy_cycles: got %0d, expected 8", bc); end
      checks++;
      if (result !== 32'h0F00_0000 || carry_out !== 1'b0) begin
         errors++; $display("FAIL add_result: got %h/%b, expected 0f000000/0", result, carry_out);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || result !== 32'h0F00_0000) begin
         errors++; $display("FAIL add_done_pulse: done=%b result=%h, expected 0 0f000000", done, result);
      end
      // cin feeds the first digit; 0x7FFFFFFF + 0 + 1 overflows signed.
      run_op(3'd0, 3'd7, 1'b1, 32'h7FFF_FFFF, 32'h0, n, bc);
      checks++;
      if (result !== 32'h8000_0000 || carry_out !== 1'b0) begin
         errors++; $display("FAIL add_cin: got %h/%b, expected 80000000/0", result, carry_out);
      end
`ifdef DIGIT_SERIAL_ALU_FLAGS_EN
      checks++;
      if (ovf !== 1'b1 || zero !== 1'b0) begin
         errors++; $display("FAIL add_ovf: zero=%b ovf=%b, expected 0 1", zero, ovf);
      end
`endif
   endtask

   task automatic test_sub;
      int n, bc;
      run_op(3'd1, 3'd7, 1'b0, 32'h2, 32'h3, n, bc);
      checks++;
      if (result !== 32'hFFFF_FFFF || carry_out !== 1'b0) begin
         errors++; $display("FAIL sub_borrow: got %h/%b, expected ffffffff/0", result, carry_out);
      end
`ifdef DIGIT_SERIAL_ALU_FLAGS_EN
      checks++;
      if (zero !== 1'b0 || ovf !== 1'b0) begin
         errors++; $display("FAIL sub_flags: zero=%b ovf=%b, expected 0 0", zero, ovf);
      end
`endif
      run_op(3'd1, 3'd7, 1'b0, 32'h5, 32'h3, n, bc);
      checks++;
      if (result !== 32'h2 || carry_out !== 1'b1) begin
         errors++; $display("FAIL sub_noborrow: got %h/%b, expected 00000002/1", result, carry_out);
      end
   endtask

   task automatic test_partial_len;
      int n, bc;
      run_op(3'd0, 3'd2, 1'b0, 32'hABCD_E001, 32'h1234_5FFE, n, bc);
      checks++;
      if (n !== 4) begin errors++; $display("FAIL len2_latency: got %0d, expected 4", n); end
      checks++;
      if (result !== 32'h0000_0FFF || carry_out !== 1'b0) begin
         errors++; $display("FAIL len2_add: got %h/%b, expected 00000fff/0", result, carry_out);
      end
      run_op(3'd7, 3'd0, 1'b0, 32'h1234_5678, 32'h0, n, bc);
      checks++;
      if (n !== 2 || result !== 32'h0000_0008) begin
         errors++; $display("FAIL len0_pass: got n=%0d %h, expected n=2 00000008", n, result);
      end
   endtask

   task automatic test_shift;
      int n, bc;
      run_op(3'd5, 3'd7, 1'b1, 32'hFFFF_FFFF, 32'h0600_0001, n, bc);
      checks++;
      if (n !== 9 || result !== 32'h0300_0000 || carry_out !== 1'b1) begin
         errors++; $display("FAIL rshft_full: got n=%0d %h/%b, expected n=9 03000000/1", n, result, carry_out);
      end
      run_op(3'd6, 3'd7, 1'b1, 32'h0, 32'h8000_0001, n, bc);
      checks++;
      if (result !== 32'h0000_0002 || carry_out !== 1'b1) begin
         errors++; $display("FAIL lshft_full: got %h/%b, expected 00000002/1", result, carry_out);
      end
      run_op(3'd5, 3'd1, 1'b0, 32'h0, 32'hFFFF_FF35, n, bc);
      checks++;
      if (n !== 3 || result !== 32'h0000_001A || carry_out !== 1'b1) begin
         errors++; $display("FAIL rshft_len1: got n=%0d %h/%b, expected n=3 0000001a/1", n, result, carry_out);
      end
      run_op(3'd6, 3'd1, 1'b0, 32'h0, 32'h0000_00C5, n, bc);
      checks++;
      if (result !== 32'h0000_008A || carry_out !== 1'b1) begin
         errors++; $display("FAIL lshft_len1: got %h/%b, expected 0000008a/1", result, carry_out);
      end
   endtask

   task automatic test_logic;
      int n, bc;
      run_op(3'd2, 3'd7, 1'b1, 32'hF0F0_F0F0, 32'h3C3C_3C3C, n, bc);
      checks++;
      if (result !== 32'h3030_3030 || carry_out !== 1'b0) begin
         errors++; $display("FAIL and: got %h/%b, expected 30303030/0", result, carry_out);
      end
      run_op(3'd3, 3'd7, 1'b1, 32'hF0F0_F0F0, 32'h3C3C_3C3C, n, bc);
      checks++;
      if (result !== 32'hFCFC_FCFC || carry_out !== 1'b0) begin
         errors++; $display("FAIL or: got %h/%b, expected fcfcfcfc/0", result, carry_out);
      end
      run_op(3'd7, 3'd7, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, n, bc);
      checks++;
      if (result !== 32'hDEAD_BEEF || carry_out !== 1'b0) begin
         errors++; $display("FAIL pass: got %h/%b, expected deadbeef/0", result, carry_out);
      end
   endtask

   task automatic test_back_to_back;
      int n;
      @(negedge clk);
      cmd = 3'd0; len = 3'd7; cin = 1'b0; a = 32'hFFFF_FFFF; b = 32'h1; start = 1'b1;
      @(negedge clk);
      // start stays high through RUN; these operands must not restart the op.
      cmd = 3'd4; a = 32'hF0F0_F0F0; b = 32'hFFFF_0000;
      n = 1;
      while (!done && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (n !== 9 || result !== 32'h0 || carry_out !== 1'b1) begin
         errors++; $display("FAIL b2b_first: got n=%0d %h/%b, expected n=9 00000000/1", n, result, carry_out);
      end
`ifdef DIGIT_SERIAL_ALU_FLAGS_EN
      checks++;
      if (zero !== 1'b1) begin errors++; $display("FAIL b2b_zero: got %b, expected 1", zero); end
`endif
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL b2b_accept: busy=%b done=%b, expected 1 0", busy, done);
      end
      n = 1;
      while (!done && n < 40) begin @(negedge clk); n++; end
      checks++;
      if (n !== 9 || result !== 32'h0F0F_F0F0 || carry_out !== 1'b0) begin
         errors++; $display("FAIL b2b_second: got n=%0d %h/%b, expected n=9 0f0ff0f0/0", n, result, carry_out);
      end
   endtask

   task automatic test_reset_mid_run;
      int n, bc;
      bit seen_done;
      @(negedge clk);
      cmd = 3'd0; len = 3'd7; cin = 1'b1; a = 32'h9999_9999; b = 32'h9999_9999; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0 || carry_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_run: busy=%b done=%b result=%h carry=%b, expected 0 0 0 0",
                  busy, done, result, carry_out);
      end
      rst = 1'b0;
      seen_done = 1'b0;
      repeat (12) begin @(negedge clk); if (done) seen_done = 1'b1; end
      checks++;
      if (seen_done !== 1'b0) begin errors++; $display("FAIL reset_no_done: got 1, expected 0"); end
      run_op(3'd0, 3'd7, 1'b0, 32'h9999_9999, 32'h9999_9999, n, bc);
      checks++;
      if (n !== 9 || result !== 32'h3333_3332 || carry_out !== 1'b1) begin
         errors++; $display("FAIL after_reset_add: got n=%0d %h/%b, expected n=9 33333332/1", n, result, carry_out);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_partial_len();
      test_shift();
      test_logic();
      test_back_to_back();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
